// File: rtl/boe_input_feeder_if.sv
// Byte-stream upstream handshake plus BOE-stage slot outputs of the input feeder.
interface boe_input_feeder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [2:0] data_num;
    logic [7:0] data_in;
    logic       frame_start;
    logic       frame_valid;
    logic       trunc_err;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, data_num, data_in, frame_start, frame_valid, trunc_err
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, data_num, data_in, frame_start, frame_valid, trunc_err
    );
endinterface

// File: rtl/boe_input_feeder.sv
// Ping-pong frame buffer feeding a BOE stage with back-to-back slots of 2N+2 cycles;
// a filler slot (N=1, frame_valid=0) is emitted whenever no complete frame is waiting.
module boe_input_feeder (
    input  logic              clk,
    input  logic              rst,
    boe_input_feeder_if.slave bus
);
    localparam int unsigned DEPTH = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 3;
    localparam int unsigned SW    = 4;

    logic [DW-1:0] mem [2][DEPTH];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    full_q, full_d;
    logic          fill_ptr_q, fill_ptr_d;
    logic          emit_ptr_q, emit_ptr_d;
    logic [SW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] num_q, num_d;
    logic [DW-1:0] din_q, din_d;
    logic          start_q, start_d;
    logic          fv_q, fv_d;
    logic          trunc_q, trunc_d;

    logic          xfer;
    logic          slot_last;
    logic          cand;
    logic [CW-1:0] fill_cnt;
    logic [SW-1:0] nxt_cyc;

    assign fill_cnt  = cnt_q[fill_ptr_q];
    assign xfer      = bus.in_valid & ~full_q[fill_ptr_q];
    assign slot_last = (cyc_q == {num_q, 1'b1});
    assign nxt_cyc   = cyc_q + SW'(1);
    // A real slot hands over to the other bank; a filler slot re-examines the same one.
    assign cand      = emit_ptr_q ^ fv_q;

    assign bus.in_ready    = ~full_q[fill_ptr_q];
    assign bus.data_num    = num_q;
    assign bus.data_in     = din_q;
    assign bus.frame_start = start_q;
    assign bus.frame_valid = fv_q;
    assign bus.trunc_err   = trunc_q;

    // Byte storage; contents are only meaningful below the bank count.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[fill_ptr_q][fill_cnt] <= bus.in_data;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        full_d     = full_q;
        fill_ptr_d = fill_ptr_q;
        emit_ptr_d = emit_ptr_q;
        cyc_d      = nxt_cyc;
        num_d      = num_q;
        din_d      = '0;
        start_d    = 1'b0;
        fv_d       = fv_q;
        trunc_d    = 1'b0;

        if (xfer) begin
            cnt_d[fill_ptr_q] = fill_cnt + CW'(1);
            if (bus.in_last || (fill_cnt == CW'(DEPTH - 1))) begin
                full_d[fill_ptr_q] = 1'b1;
                fill_ptr_d         = ~fill_ptr_q;
            end
            trunc_d = (fill_cnt == CW'(DEPTH - 1)) && !bus.in_last;
        end

        if (slot_last) begin
            // Fill and emit banks never coincide here while a write is possible.
            if (fv_q) begin
                cnt_d[emit_ptr_q]  = '0;
                full_d[emit_ptr_q] = 1'b0;
            end
            emit_ptr_d = cand;
            cyc_d      = '0;
            start_d    = 1'b1;
            if (full_q[cand]) begin
                num_d = cnt_q[cand];
                din_d = mem[cand][0];
                fv_d  = 1'b1;
            end else begin
                num_d = CW'(1);
                fv_d  = 1'b0;
            end
        end else if (nxt_cyc < SW'(num_q)) begin
            din_d = mem[emit_ptr_q][CW'(nxt_cyc)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '{default: '0};
            full_q     <= '0;
            fill_ptr_q <= 1'b0;
            emit_ptr_q <= 1'b0;
            cyc_q      <= '0;
            num_q      <= CW'(1);
            din_q      <= '0;
            start_q    <= 1'b1;
            fv_q       <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            fill_ptr_q <= fill_ptr_d;
            emit_ptr_q <= emit_ptr_d;
            cyc_q      <= cyc_d;
            num_q      <= num_d;
            din_q      <= din_d;
            start_q    <= start_d;
            fv_q       <= fv_d;
            trunc_q    <= trunc_d;
        end
    end
endmodule

// File: tb/tb_boe_input_feeder.sv
// Directed bench for boe_input_feeder: per-cycle slot words and in_ready against hand-built slot tables.
module tb_boe_input_feeder;
    logic clk = 1'b0;
    logic rst;

    boe_input_feeder_if bif ();

    boe_input_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [13:0] logw [64];
    logic        logr [64];

    // Expected slot table: start cycle, N, frame_valid, byte k = base + step*k.
    int sl_cnt;
    int sl_start [8];
    int sl_num   [8];
    bit sl_fv    [8];
    int sl_base  [8];
    int sl_step  [8];
    int trunc_at;
    int bz_a [2];
    int bz_b [2];

    function automatic logic [13:0] exp_word(input int c);
        int s = 0;
        int off;
        logic [7:0] din;
        for (int i = 0; i < sl_cnt; i++) if (c >= sl_start[i]) s = i;
        off = c - sl_start[s];
        din = (sl_fv[s] && off < sl_num[s]) ? 8'(sl_base[s] + sl_step[s] * off) : 8'd0;
        return {(c == trunc_at), (off == 0), sl_fv[s], 3'(sl_num[s]), din};
    endfunction

    function automatic logic exp_ready(input int c);
        return !((c >= bz_a[0] && c < bz_b[0]) || (c >= bz_a[1] && c < bz_b[1]));
    endfunction

    task automatic add_slot(input int start, input int num, input bit fv, input int base, input int step);
        sl_start[sl_cnt] = start;
        sl_num[sl_cnt]   = num;
        sl_fv[sl_cnt]    = fv;
        sl_base[sl_cnt]  = base;
        sl_step[sl_cnt]  = step;
        sl_cnt++;
    endtask

    // Leaves the bench at the negedge of the first cycle after the reset edge.
    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_data  = 8'd0;
        bif.in_last  = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        sl_cnt   = 0;
        trunc_at = -1;
        bz_a     = '{0, 0};
        bz_b     = '{0, 0};
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        bif.in_last  = l;
        while (bif.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL send_timeout byte %0d: in_ready stayed %b, required 1", d, bif.in_ready);
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int step, input int n, input bit last);
        for (int k = 0; k < n; k++) send_byte(8'(base + step * k), last && (k == n - 1));
    endtask

    task automatic log_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            logw[c] = {bif.trunc_err, bif.frame_start, bif.frame_valid, bif.data_num, bif.data_in};
            logr[c] = bif.in_ready;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bif.data_num !== 3'd1)   begin errors++; $display("FAIL reset data_num got %0d want 1", bif.data_num); end
        checks++; if (bif.data_in !== 8'd0)    begin errors++; $display("FAIL reset data_in got %0d want 0", bif.data_in); end
        checks++; if (bif.frame_start !== 1'b1) begin errors++; $display("FAIL reset frame_start got %b want 1", bif.frame_start); end
        checks++; if (bif.frame_valid !== 1'b0) begin errors++; $display("FAIL reset frame_valid got %b want 0", bif.frame_valid); end
        checks++; if (bif.trunc_err !== 1'b0)  begin errors++; $display("FAIL reset trunc_err got %b want 0", bif.trunc_err); end
        checks++; if (bif.in_ready !== 1'b1)   begin errors++; $display("FAIL reset in_ready got %b want 1", bif.in_ready); end
    endtask

    task automatic test_idle();
        logic [12:0] got, want;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            got  = {bif.frame_start, bif.frame_valid, bif.data_num, bif.data_in};
            want = {(c % 4 == 0), 1'b0, 3'd1, 8'd0};
            checks++;
            if (got !== want) begin errors++; $display("FAIL idle cyc %0d got %h want %h", c, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        do_reset();
        add_slot(0, 1, 0, 0, 0);  add_slot(4, 3, 1, 10, 10);
        add_slot(12, 1, 0, 0, 0); add_slot(16, 1, 0, 0, 0);
        fork
            send_frame(10, 10, 3, 1);
            log_cycles(20);
        join
        for (int c = 0; c < 20; c++) begin
            checks++; if (logw[c] !== exp_word(c)) begin errors++; $display("FAIL single cyc %0d word got %h want %h", c, logw[c], exp_word(c)); end
            checks++; if (logr[c] !== exp_ready(c)) begin errors++; $display("FAIL single cyc %0d in_ready got %b want %b", c, logr[c], exp_ready(c)); end
        end
    endtask

    task automatic test_trunc();
        do_reset();
        add_slot(0, 1, 0, 0, 0);  add_slot(4, 1, 0, 0, 0); add_slot(8, 6, 1, 1, 1);
        add_slot(22, 1, 1, 7, 0); add_slot(26, 1, 0, 0, 0);
        trunc_at = 6;
        bz_a[0]  = 7; bz_b[0] = 22;
        fork
            begin send_frame(1, 1, 6, 0); send_frame(7, 1, 1, 1); end
            log_cycles(30);
        join
        for (int c = 0; c < 30; c++) begin
            checks++; if (logw[c] !== exp_word(c)) begin errors++; $display("FAIL trunc cyc %0d word got %h want %h", c, logw[c], exp_word(c)); end
            checks++; if (logr[c] !== exp_ready(c)) begin errors++; $display("FAIL trunc cyc %0d in_ready got %b want %b", c, logr[c], exp_ready(c)); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        add_slot(0, 1, 0, 0, 0);   add_slot(4, 1, 0, 0, 0);   add_slot(8, 6, 1, 11, 1);
        add_slot(22, 6, 1, 21, 1); add_slot(36, 6, 1, 31, 1);
        bz_a = '{12, 28}; bz_b = '{22, 36};
        fork
            begin send_frame(11, 1, 6, 1); send_frame(21, 1, 6, 1); send_frame(31, 1, 6, 1); end
            log_cycles(50);
        join
        for (int c = 0; c < 50; c++) begin
            checks++; if (logw[c] !== exp_word(c)) begin errors++; $display("FAIL b2b cyc %0d word got %h want %h", c, logw[c], exp_word(c)); end
            checks++; if (logr[c] !== exp_ready(c)) begin errors++; $display("FAIL b2b cyc %0d in_ready got %b want %b", c, logr[c], exp_ready(c)); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_frame(51, 1, 5, 1);
        send_frame(61, 1, 2, 0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bif.frame_valid, bif.data_num, bif.data_in} !== {1'b1, 3'd5, 8'd53}) begin
            errors++;
            $display("FAIL midrst pre fv/num/din got %b/%0d/%0d want 1/5/53", bif.frame_valid, bif.data_num, bif.data_in);
        end
        do_reset();
        checks++;
        if ({bif.frame_start, bif.frame_valid, bif.data_num, bif.data_in, bif.in_ready, bif.trunc_err}
            !== {1'b1, 1'b0, 3'd1, 8'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midrst post fs/fv/num/din/rdy got %b/%b/%0d/%0d/%b want 1/0/1/0/1",
                     bif.frame_start, bif.frame_valid, bif.data_num, bif.data_in, bif.in_ready);
        end
        add_slot(0, 1, 0, 0, 0); add_slot(4, 1, 0, 0, 0); add_slot(8, 1, 0, 0, 0); add_slot(12, 1, 0, 0, 0);
        log_cycles(16);
        for (int c = 0; c < 16; c++) begin
            checks++; if (logw[c] !== exp_word(c)) begin errors++; $display("FAIL midrst cyc %0d word got %h want %h", c, logw[c], exp_word(c)); end
            checks++; if (logr[c] !== exp_ready(c)) begin errors++; $display("FAIL midrst cyc %0d in_ready got %b want %b", c, logr[c], exp_ready(c)); end
        end
    endtask

    task automatic test_release_write();
        do_reset();
        add_slot(0, 1, 0, 0, 0);  add_slot(4, 3, 1, 1, 1);  add_slot(12, 1, 0, 0, 0);
        add_slot(16, 3, 1, 4, 1); add_slot(24, 2, 1, 7, 1); add_slot(30, 1, 0, 0, 0);
        bz_a[0] = 14; bz_b[0] = 24;
        fork
            begin
                send_frame(1, 1, 3, 1);
                repeat (6) @(negedge clk);
                send_frame(4, 1, 3, 1);
                send_frame(7, 1, 2, 1);
            end
            log_cycles(34);
        join
        for (int c = 0; c < 34; c++) begin
            checks++; if (logw[c] !== exp_word(c)) begin errors++; $display("FAIL relwr cyc %0d word got %h want %h", c, logw[c], exp_word(c)); end
            checks++; if (logr[c] !== exp_ready(c)) begin errors++; $display("FAIL relwr cyc %0d in_ready got %b want %b", c, logr[c], exp_ready(c)); end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_data  = 8'd0;
        bif.in_last  = 1'b0;
        test_reset();
        test_idle();
        test_single();
        test_trunc();
        test_back_to_back();
        test_mid_reset();
        test_release_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
